// File: rtl/bubble_sorter_pkg.sv
// bubble_pkg: sorter state encoding, register-file mode codes, width defaults
// and the length clamp shared by the sorter and its pass counter.
package bubble_pkg;

   localparam int DEF_DEPTH = 32;
   localparam int DEF_AW    = 5;
   localparam int DEF_DW    = 32;
   localparam int LEN_W     = 6;
   localparam int SWAP_W    = 10;

   localparam logic [1:0] RF_READ  = 2'b00;
   localparam logic [1:0] RF_WRITE = 2'b01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_B,
      ST_CMP,
      ST_WR_A,
      ST_WR_B,
      ST_NEXT,
      ST_DONE
   } state_t;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int depth);
      if (int'(len) > depth) return LEN_W'(depth);
      return len;
   endfunction

endpackage

// File: rtl/bubble_sorter_if.sv
// bubble_sorter_if: sequencer control (start/len/busy/done/swap_count) plus the
// register-file address/mode/data port; master is the sorter side.
interface bubble_sorter_if #(
   parameter int AW = 5,
   parameter int DW = 32
) ();
   logic          start;
   logic [5:0]    len;
   logic          busy;
   logic          done;
   logic [9:0]    swap_count;
   logic [AW-1:0] rf_addr_wr;
   logic [AW-1:0] rf_addr_rd;
   logic [1:0]    rf_mode;
   logic [DW-1:0] rf_wdata;
   logic [DW-1:0] rf_rdata;

   modport master (
      input  start, len, rf_rdata,
      output busy, done, swap_count, rf_addr_wr, rf_addr_rd, rf_mode, rf_wdata
   );

   modport slave (
      output start, len, rf_rdata,
      input  busy, done, swap_count, rf_addr_wr, rf_addr_rd, rf_mode, rf_wdata
   );
endinterface

// File: rtl/bubble_sorter_pass_ctr.sv
// bubble_pass_ctr: pass index p and compare index j with end-of-pass/end-of-sort flags.
// Latency: flags are combinational from the registered counters and the latched length.
// No backpressure: counters move only on the load/inc/next strobes from the FSM.
module bubble_pass_ctr
   import bubble_pkg::*;
#(
   parameter int AW = DEF_AW
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_inc_j,
   input  logic             i_next_pass,
   output logic [AW-1:0]    o_j,
   output logic             o_end_of_pass,
   output logic             o_end_of_sort
);
   logic [LEN_W-1:0] r_len;
   logic [AW-1:0]    r_p;
   logic [AW-1:0]    r_j;
   logic [LEN_W-1:0] w_last_j;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_len <= '0;
         r_p   <= '0;
         r_j   <= '0;
      end else if (i_load) begin
         r_len <= i_len;
         r_p   <= '0;
         r_j   <= '0;
      end else if (i_next_pass) begin
         r_p   <= r_p + AW'(1);
         r_j   <= '0;
      end else if (i_inc_j) begin
         r_j   <= r_j + AW'(1);
      end
   end

   // len >= 2 and p <= len-2 whenever these are consulted, so no underflow.
   assign w_last_j      = r_len - LEN_W'(2) - LEN_W'(r_p);
   assign o_end_of_pass = !(LEN_W'(r_j) < w_last_j);
   assign o_end_of_sort = (LEN_W'(r_p) + LEN_W'(2)) == r_len;
   assign o_j           = r_j;

endmodule

// File: rtl/bubble_sorter.sv
// bubble_sorter: in-place ascending unsigned bubble sort over a read/write register-file port.
// Latency: 3 cycles per compare, +2 per swap, +1 per pass boundary, then a 1-cycle done pulse.
// No backpressure: start is ignored while busy; BUBBLE_EARLY_EXIT_EN ends after a swap-free pass.
module bubble_sorter
   import bubble_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_AW,
   parameter int DW    = DEF_DW
)(
   input  logic            clk,
   input  logic            rst,
   bubble_sorter_if.master bus
);
   state_t            r_state;
   state_t            w_state_nxt;
   logic [DW-1:0]     r_a;
   logic [DW-1:0]     r_b;
   logic [SWAP_W-1:0] r_swap_count;

   logic [LEN_W-1:0]  w_len_c;
   logic [AW-1:0]     w_j;
   logic [AW-1:0]     w_j1;
   logic              w_end_pass;
   logic              w_end_sort;
   logic              w_load;
   logic              w_inc_j;
   logic              w_next_pass;
   logic              w_early_exit;
   logic              w_swap;
   logic [1:0]        w_mode;
   logic [AW-1:0]     w_addr_wr;
   logic [AW-1:0]     w_addr_rd;
   logic [DW-1:0]     w_wdata;

   assign w_len_c = clamp_len(bus.len, DEPTH);
   assign w_j1    = w_j + AW'(1);
   // Strict compare keeps equal keys in place, so the sort is stable.
   assign w_swap  = r_a > bus.rf_rdata;

   bubble_pass_ctr #(.AW(AW)) u_pass_ctr (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_load),
      .i_len         (w_len_c),
      .i_inc_j       (w_inc_j),
      .i_next_pass   (w_next_pass),
      .o_j           (w_j),
      .o_end_of_pass (w_end_pass),
      .o_end_of_sort (w_end_sort)
   );

`ifdef BUBBLE_EARLY_EXIT_EN
   logic r_pass_swapped;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_pass_swapped <= 1'b0;
      else if (w_load || w_next_pass)
         r_pass_swapped <= 1'b0;
      else if (r_state == ST_WR_B)
         r_pass_swapped <= 1'b1;
   end

   assign w_early_exit = !r_pass_swapped;
`else
   assign w_early_exit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_swap_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_RD_B)
            r_a <= bus.rf_rdata;
         if (r_state == ST_CMP)
            r_b <= bus.rf_rdata;
         if (w_load)
            r_swap_count <= '0;
         else if (r_state == ST_WR_B)
            r_swap_count <= r_swap_count + SWAP_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_inc_j     = 1'b0;
      w_next_pass = 1'b0;
      w_mode      = RF_READ;
      w_addr_wr   = '0;
      w_addr_rd   = '0;
      w_wdata     = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (w_len_c <= LEN_W'(1)) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_RD_A;
               end
            end
         end
         ST_RD_A: begin
            w_addr_rd   = w_j;
            w_state_nxt = ST_RD_B;
         end
         ST_RD_B: begin
            w_addr_rd   = w_j1;
            w_state_nxt = ST_CMP;
         end
         ST_CMP: begin
            if (w_swap) begin
               w_state_nxt = ST_WR_A;
            end else if (w_end_pass) begin
               w_state_nxt = ST_NEXT;
            end else begin
               w_inc_j     = 1'b1;
               w_state_nxt = ST_RD_A;
            end
         end
         ST_WR_A: begin
            w_mode      = RF_WRITE;
            w_addr_wr   = w_j;
            w_wdata     = r_b;
            w_state_nxt = ST_WR_B;
         end
         ST_WR_B: begin
            w_mode    = RF_WRITE;
            w_addr_wr = w_j1;
            w_wdata   = r_a;
            if (w_end_pass) begin
               w_state_nxt = ST_NEXT;
            end else begin
               w_inc_j     = 1'b1;
               w_state_nxt = ST_RD_A;
            end
         end
         ST_NEXT: begin
            w_next_pass = 1'b1;
            if (w_end_sort || w_early_exit)
               w_state_nxt = ST_DONE;
            else
               w_state_nxt = ST_RD_A;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.done       = (r_state == ST_DONE);
   assign bus.swap_count = r_swap_count;
   assign bus.rf_mode    = w_mode;
   assign bus.rf_addr_wr = w_addr_wr;
   assign bus.rf_addr_rd = w_addr_rd;
   assign bus.rf_wdata   = w_wdata;

endmodule

// File: tb/tb_bubble_sorter.sv
// tb_bubble_sorter: drives bubble_sorter against a behavioural register file and
// checks contents, swap count and DONE timing against a rank/inversion model.
module tb_bubble_sorter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld;
   logic [31:0] mem   [32];
   logic [31:0] img   [32];
   logic [31:0] exp_m [32];
   int          errors = 0;
   int          checks = 0;
   int          wr_cnt = 0;
   int          bad_mode = 0;
   int          cyc;
   int          sc_done;
   int          inv_exp;
   int          cyc_exp;
   logic        d_after;
   logic        b_after;

   bubble_sorter_if #(.AW(5), .DW(32)) bus ();

   bubble_sorter #(.DEPTH(32), .AW(5), .DW(32)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Register file: synchronous write, read data one cycle after a read.
   always @(posedge clk) begin
      if (ld)
         mem <= img;
      else if (bus.rf_mode == 2'b01)
         mem[bus.rf_addr_wr] <= bus.rf_wdata;
      if (bus.rf_mode == 2'b00)
         bus.rf_rdata <= mem[bus.rf_addr_rd];
      if (bus.rf_mode == 2'b01)
         wr_cnt <= wr_cnt + 1;
      if (bus.rf_mode[1])
         bad_mode <= bad_mode + 1;
   end

   task automatic load_img();
      @(negedge clk); ld = 1'b1;
      @(negedge clk); ld = 1'b0;
   endtask

   // Expected result from ranks; swaps = inversions; passes from max left-greater count.
   task automatic model(input int l);
      int n, lg, pos, maxl, passes;
      n = (l > 32) ? 32 : l;
      inv_exp = 0;
      maxl = 0;
      for (int i = 0; i < 32; i++) exp_m[i] = img[i];
      for (int i = 0; i < n; i++) begin
         lg = 0;
         pos = 0;
         for (int k = 0; k < n; k++) begin
            if (img[k] < img[i]) pos++;
            else if (img[k] == img[i] && k < i) pos++;
            if (k < i && img[k] > img[i]) lg++;
         end
         exp_m[pos] = img[i];
         inv_exp += lg;
         if (lg > maxl) maxl = lg;
      end
      if (n <= 1) begin
         cyc_exp = 1;
      end else begin
         passes = n - 1;
`ifdef BUBBLE_EARLY_EXIT_EN
         if (maxl + 1 < passes) passes = maxl + 1;
`endif
         cyc_exp = 2 * inv_exp + 1;
         for (int p = 0; p < passes; p++) cyc_exp += 3 * (n - 1 - p) + 1;
      end
   endtask

   function automatic int mism();
      int m = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== exp_m[i]) m++;
      return m;
   endfunction

   // Start at edge 0; cyc counts cycles after acceptance until done is seen.
   task automatic run_sort(input int l, input int poke);
      @(negedge clk); bus.start = 1'b1; bus.len = l[5:0];
      @(negedge clk); bus.start = 1'b0; cyc = 1;
      while (bus.done !== 1'b1 && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == poke);
         if (cyc == poke) bus.len = 6'd2;
      end
      bus.start = 1'b0;
      sc_done = int'(bus.swap_count);
      @(negedge clk);
      d_after = bus.done;
      b_after = bus.busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.start = 1'b0; bus.len = '0; ld = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.swap_count, bus.rf_mode, bus.rf_addr_wr, bus.rf_addr_rd, bus.rf_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b sc=%0d mode=%b awr=%0d ard=%0d wd=%h want all 0",
                  bus.busy, bus.done, bus.swap_count, bus.rf_mode, bus.rf_addr_wr, bus.rf_addr_rd, bus.rf_wdata);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.rf_mode !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b mode=%b want 0 00", bus.busy, bus.rf_mode);
      end
   endtask

   task automatic test_short();
      int wr0;
      for (int l = 0; l < 2; l++) begin
         for (int i = 0; i < 32; i++) img[i] = $urandom;
         load_img();
         model(l);
         wr0 = wr_cnt;
         run_sort(l, 0);
         checks++;
         if (cyc !== 1) begin errors++; $display("FAIL short_done_cycle len=%0d: got %0d want 1", l, cyc); end
         checks++;
         if (wr_cnt !== wr0) begin errors++; $display("FAIL short_no_write len=%0d: writes=%0d want 0", l, wr_cnt - wr0); end
         checks++;
         if (sc_done !== 0 || mism() !== 0) begin
            errors++; $display("FAIL short_state len=%0d: sc=%0d mism=%0d want 0 0", l, sc_done, mism());
         end
      end
   endtask

   task automatic test_reversed4();
      for (int i = 0; i < 32; i++) img[i] = (i < 4) ? 32'(4 - i) : $urandom;
      load_img();
      model(4);
      run_sort(4, 0);
      checks++;
      if (mism() !== 0) begin errors++; $display("FAIL rev4_contents: mismatches=%0d want 0", mism()); end
      checks++;
      if (sc_done !== 6) begin errors++; $display("FAIL rev4_swaps: got %0d want 6", sc_done); end
      checks++;
      if (cyc !== 34) begin errors++; $display("FAIL rev4_done_cycle: got %0d want 34", cyc); end
      checks++;
      if (d_after !== 1'b0 || b_after !== 1'b0) begin
         errors++; $display("FAIL rev4_done_pulse: done=%b busy=%b after DONE want 0 0", d_after, b_after);
      end
   endtask

   task automatic test_sorted4();
      int want;
`ifdef BUBBLE_EARLY_EXIT_EN
      want = 11;
`else
      want = 22;
`endif
      for (int i = 0; i < 32; i++) img[i] = (i < 4) ? 32'(i + 1) : $urandom;
      load_img();
      model(4);
      run_sort(4, 0);
      checks++;
      if (mism() !== 0 || sc_done !== 0) begin
         errors++; $display("FAIL sorted4_state: mism=%0d sc=%0d want 0 0", mism(), sc_done);
      end
      checks++;
      if (cyc !== want) begin errors++; $display("FAIL sorted4_done_cycle: got %0d want %0d", cyc, want); end
   endtask

   task automatic test_clamp();
      for (int i = 0; i < 32; i++) img[i] = 32'(32 - i);
      load_img();
      model(40);
      run_sort(40, 0);
      checks++;
      if (mism() !== 0) begin errors++; $display("FAIL clamp_contents: mismatches=%0d want 0", mism()); end
      checks++;
      if (sc_done !== 496) begin errors++; $display("FAIL clamp_swaps: got %0d want 496", sc_done); end
      checks++;
      if (cyc !== cyc_exp) begin errors++; $display("FAIL clamp_done_cycle: got %0d want %0d", cyc, cyc_exp); end
   endtask

   task automatic test_equal();
      int wr0;
      for (int i = 0; i < 32; i++) img[i] = (i < 2) ? 32'd5 : $urandom;
      load_img();
      model(2);
      wr0 = wr_cnt;
      run_sort(2, 0);
      checks++;
      if (sc_done !== 0 || wr_cnt !== wr0 || mism() !== 0) begin
         errors++; $display("FAIL equal_no_swap: sc=%0d writes=%0d mism=%0d want 0 0 0", sc_done, wr_cnt - wr0, mism());
      end
   endtask

   task automatic test_ffff();
      for (int i = 0; i < 32; i++) img[i] = $urandom_range(0, 1000);
      img[0] = 32'hFFFF_FFFF;
      img[3] = 32'h8000_0000;
      load_img();
      model(6);
      run_sort(6, 0);
      checks++;
      if (mem[5] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ffff_last: got %h want ffffffff", mem[5]); end
      checks++;
      if (mism() !== 0 || sc_done !== inv_exp) begin
         errors++; $display("FAIL ffff_sort: mism=%0d sc=%0d want 0 %0d", mism(), sc_done, inv_exp);
      end
   endtask

   task automatic test_busy_start();
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load_img();
      model(6);
      run_sort(6, 5);
      checks++;
      if (mism() !== 0 || sc_done !== inv_exp) begin
         errors++; $display("FAIL busy_start_sort: mism=%0d sc=%0d want 0 %0d", mism(), sc_done, inv_exp);
      end
      checks++;
      if (cyc !== cyc_exp) begin errors++; $display("FAIL busy_start_cycle: got %0d want %0d", cyc, cyc_exp); end
      repeat (3) @(negedge clk);
      checks++;
      if (b_after !== 1'b0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL busy_start_idle: busy=%b/%b want 0", b_after, bus.busy);
      end
   endtask

   task automatic test_reset_mid_sort();
      for (int i = 0; i < 32; i++) img[i] = (i < 8) ? 32'(8 - i) : $urandom;
      load_img();
      @(negedge clk); bus.start = 1'b1; bus.len = 6'd8;
      @(negedge clk); bus.start = 1'b0; cyc = 1;
      while (cyc < 17) begin @(negedge clk); cyc++; end
      checks++;
      if (bus.rf_addr_rd !== 5'd4 || bus.rf_mode !== 2'b00 || bus.swap_count !== 10'd3) begin
         errors++; $display("FAIL mid_sort_rd_b: ard=%0d mode=%b sc=%0d want 4 00 3", bus.rf_addr_rd, bus.rf_mode, bus.swap_count);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.rf_mode !== 2'b00 || bus.swap_count !== 10'd0) begin
         errors++; $display("FAIL mid_sort_reset: busy=%b mode=%b sc=%0d want 0 00 0", bus.busy, bus.rf_mode, bus.swap_count);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 32; i++) img[i] = $urandom;
      load_img();
      model(10);
      run_sort(10, 0);
      checks++;
      if (mism() !== 0 || sc_done !== inv_exp || cyc !== cyc_exp) begin
         errors++; $display("FAIL after_reset_sort: mism=%0d sc=%0d cyc=%0d want 0 %0d %0d", mism(), sc_done, cyc, inv_exp, cyc_exp);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int l;
         l = $urandom_range(2, 32);
         for (int i = 0; i < 32; i++) img[i] = (it % 2 == 1) ? 32'($urandom_range(0, 7)) : $urandom;
         load_img();
         model(l);
         run_sort(l, 0);
         checks++;
         if (mism() !== 0) begin errors++; $display("FAIL rand%0d_contents len=%0d: mismatches=%0d want 0", it, l, mism()); end
         checks++;
         if (sc_done !== inv_exp) begin errors++; $display("FAIL rand%0d_swaps len=%0d: got %0d want %0d", it, l, sc_done, inv_exp); end
         checks++;
         if (cyc !== cyc_exp) begin errors++; $display("FAIL rand%0d_cycle len=%0d: got %0d want %0d", it, l, cyc, cyc_exp); end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_reversed4();
      test_sorted4();
      test_clamp();
      test_equal();
      test_ffff();
      test_busy_start();
      test_reset_mid_sort();
      test_random();
      checks++;
      if (bad_mode !== 0) begin errors++; $display("FAIL illegal_mode: cycles=%0d want 0", bad_mode); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
